// File: rtl/nfca_rx_frame_ctrl.sv
// nfca_rx_frame_ctrl
// Sequences the NFC-A RX byte assembler for one PICC response frame:
// guard time after the request, enabling the assembler (rx_on), frame-wait
// timeout, forwarding data beats and emitting a one-cycle frame summary.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   start              open a receive window (ignored while busy)
//   start_remainb      bits remaining in an incomplete first byte (latched)
//   start_timeout      frame-wait limit in clk cycles, 0 = TIMEOUT_DEFAULT
//   abort              terminate the current window
//   rx_col             collision-end pulse from the bit parser (sticky flag)
//   busy, rx_on        window active / byte assembler enable
//   remainb            latched start_remainb
//   rx_t*              byte beats from the assembler (no backpressure)
//   o_valid/o_data/o_bits  forwarded data byte, one-cycle strobe
//   frame_*            frame summary, valid with the frame_done pulse and
//                      held until the next frame_done
//   dbg_state          current FSM state
//
// Beat interface: a beat is transferred in every cycle rx_tvalid is high;
// there is no ready, the assembler never waits. o_valid likewise carries no
// ready and is a single-cycle strobe per forwarded byte.
module nfca_rx_frame_ctrl #(
  parameter int                      GUARD_CYCLES    = 512,
  parameter int                      TIMEOUT_W       = 20,
  parameter logic [TIMEOUT_W-1:0]    TIMEOUT_DEFAULT = 20'd400000,
  parameter int                      MAX_BYTES       = 64,
  parameter int                      LEN_W           = $clog2(MAX_BYTES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           start_remainb,
  input  logic [TIMEOUT_W-1:0] start_timeout,
  input  logic                 abort,
  input  logic                 rx_col,
  output logic                 busy,
  output logic                 rx_on,
  output logic [2:0]           remainb,
  input  logic                 rx_tvalid,
  input  logic [7:0]           rx_tdata,
  input  logic [3:0]           rx_tdatab,
  input  logic                 rx_tend,
  input  logic                 rx_terr,
  output logic                 o_valid,
  output logic [7:0]           o_data,
  output logic [3:0]           o_bits,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     frame_len,
  output logic [3:0]           frame_lastbits,
  output logic                 frame_col,
  output logic                 frame_err,
  output logic                 frame_timeout,
  output logic [2:0]           dbg_state
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GUARD, S_LISTEN, S_RECV, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 drain_q, drain_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [3:0]           lastbits_q, lastbits_d;
  logic                 col_q, col_d, err_q, err_d, tout_q, tout_d;
  logic                 busy_q, busy_d, rx_on_q, rx_on_d;
  logic [2:0]           remainb_q, remainb_d;
  logic                 o_valid_q, o_valid_d;
  logic [7:0]           o_data_q, o_data_d;
  logic [3:0]           o_bits_q, o_bits_d;
  logic                 frame_done_q, frame_done_d;
  logic [LEN_W-1:0]     frame_len_q, frame_len_d;
  logic [3:0]           frame_lastbits_q, frame_lastbits_d;
  logic                 frame_col_q, frame_col_d, frame_err_q, frame_err_d;
  logic                 frame_timeout_q, frame_timeout_d;

  always_comb begin
    state_d          = state_q;
    guard_d          = guard_q;
    tmo_d            = tmo_q;
    drain_d          = 1'b0;
    len_d            = len_q;
    lastbits_d       = lastbits_q;
    col_d            = col_q;
    err_d            = err_q;
    tout_d           = tout_q;
    remainb_d        = remainb_q;
    o_valid_d        = 1'b0;
    o_data_d         = o_data_q;
    o_bits_d         = o_bits_q;
    frame_done_d     = 1'b0;
    frame_len_d      = frame_len_q;
    frame_lastbits_d = frame_lastbits_q;
    frame_col_d      = frame_col_q;
    frame_err_d      = frame_err_q;
    frame_timeout_d  = frame_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remainb_d  = start_remainb;
          tmo_d      = (start_timeout == '0) ? TIMEOUT_DEFAULT : start_timeout;
          guard_d    = GW'(GUARD_CYCLES - 1);
          len_d      = '0;
          lastbits_d = '0;
          col_d      = 1'b0;
          err_d      = 1'b0;
          tout_d     = 1'b0;
          state_d    = S_GUARD;
        end
      end
      S_GUARD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (guard_q == '0) begin
          state_d = S_LISTEN;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      S_LISTEN, S_RECV: begin
        if (rx_col) col_d = 1'b1;
        // Priority: abort, then the beat, then timeout expiry.
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (rx_tvalid) begin
          if (rx_tdatab != 4'd0 && len_q == LEN_W'(MAX_BYTES)) begin
            // Overflow: the beat is dropped and the window is closed.
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            if (rx_tdatab != 4'd0) begin
              o_valid_d  = 1'b1;
              o_data_d   = rx_tdata;
              o_bits_d   = rx_tdatab;
              len_d      = len_q + 1'b1;
              lastbits_d = rx_tdatab;
            end
            if (rx_tend) begin
              err_d   = err_q | rx_terr;
              state_d = S_DRAIN;
            end else begin
              state_d = S_RECV;
            end
          end
        end else if (state_q == S_LISTEN) begin
          // rx_on stays high for exactly the latched number of cycles.
          if (tmo_q <= TIMEOUT_W'(1)) begin
            tout_d  = 1'b1;
            state_d = S_DRAIN;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles with rx_on low; beats here (including the assembler's
        // rx_on-off error beat) are discarded.
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          state_d          = S_DONE;
          frame_done_d     = 1'b1;
          frame_len_d      = len_q;
          frame_lastbits_d = lastbits_q;
          frame_col_d      = col_q;
          frame_err_d      = err_q;
          frame_timeout_d  = tout_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    rx_on_d = (state_d == S_LISTEN) || (state_d == S_RECV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      guard_q          <= '0;
      tmo_q            <= '0;
      drain_q          <= 1'b0;
      len_q            <= '0;
      lastbits_q       <= '0;
      col_q            <= 1'b0;
      err_q            <= 1'b0;
      tout_q           <= 1'b0;
      busy_q           <= 1'b0;
      rx_on_q          <= 1'b0;
      remainb_q        <= '0;
      o_valid_q        <= 1'b0;
      o_data_q         <= '0;
      o_bits_q         <= '0;
      frame_done_q     <= 1'b0;
      frame_len_q      <= '0;
      frame_lastbits_q <= '0;
      frame_col_q      <= 1'b0;
      frame_err_q      <= 1'b0;
      frame_timeout_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      guard_q          <= guard_d;
      tmo_q            <= tmo_d;
      drain_q          <= drain_d;
      len_q            <= len_d;
      lastbits_q       <= lastbits_d;
      col_q            <= col_d;
      err_q            <= err_d;
      tout_q           <= tout_d;
      busy_q           <= busy_d;
      rx_on_q          <= rx_on_d;
      remainb_q        <= remainb_d;
      o_valid_q        <= o_valid_d;
      o_data_q         <= o_data_d;
      o_bits_q         <= o_bits_d;
      frame_done_q     <= frame_done_d;
      frame_len_q      <= frame_len_d;
      frame_lastbits_q <= frame_lastbits_d;
      frame_col_q      <= frame_col_d;
      frame_err_q      <= frame_err_d;
      frame_timeout_q  <= frame_timeout_d;
    end
  end

  assign busy           = busy_q;
  assign rx_on          = rx_on_q;
  assign remainb        = remainb_q;
  assign o_valid        = o_valid_q;
  assign o_data         = o_data_q;
  assign o_bits         = o_bits_q;
  assign frame_done     = frame_done_q;
  assign frame_len      = frame_len_q;
  assign frame_lastbits = frame_lastbits_q;
  assign frame_col      = frame_col_q;
  assign frame_err      = frame_err_q;
  assign frame_timeout  = frame_timeout_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nfca_rx_frame_ctrl.sv
module tb_nfca_rx_frame_ctrl;

  localparam int G       = 8;
  localparam int TW      = 20;
  localparam int MAXB    = 4;
  localparam int LW      = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    start_remainb = '0;
  logic [TW-1:0] start_timeout = '0;
  logic          abort = 1'b0;
  logic          rx_col = 1'b0;
  logic          busy, rx_on;
  logic [2:0]    remainb;
  logic          rx_tvalid = 1'b0;
  logic [7:0]    rx_tdata = '0;
  logic [3:0]    rx_tdatab = '0;
  logic          rx_tend = 1'b0;
  logic          rx_terr = 1'b0;
  logic          o_valid;
  logic [7:0]    o_data;
  logic [3:0]    o_bits;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic [3:0]    frame_lastbits;
  logic          frame_col, frame_err, frame_timeout;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic seen_rx_on;
  logic [11:0] exp_q[$];

  nfca_rx_frame_ctrl #(
    .GUARD_CYCLES(G), .TIMEOUT_W(TW), .TIMEOUT_DEFAULT(20'd400000),
    .MAX_BYTES(MAXB), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_remainb(start_remainb),
    .start_timeout(start_timeout), .abort(abort), .rx_col(rx_col),
    .busy(busy), .rx_on(rx_on), .remainb(remainb),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tdatab(rx_tdatab),
    .rx_tend(rx_tend), .rx_terr(rx_terr),
    .o_valid(o_valid), .o_data(o_data), .o_bits(o_bits),
    .frame_done(frame_done), .frame_len(frame_len),
    .frame_lastbits(frame_lastbits), .frame_col(frame_col),
    .frame_err(frame_err), .frame_timeout(frame_timeout),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every o_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) chk("unexpected_o_valid", 32'd1, 32'd0);
      else chk("o_byte", {20'd0, o_bits, o_data}, {20'd0, exp_q.pop_front()});
    end
    if (!rst && frame_done) done_cnt++;
  end

  // Drivers
  task automatic do_start(input logic [2:0] rb, input logic [TW-1:0] tmo);
    start = 1'b1; start_remainb = rb; start_timeout = tmo;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [3:0] b,
                           input logic te, input logic tr, input logic col,
                           input logic fwd);
    rx_tvalid = 1'b1; rx_tdata = d; rx_tdatab = b; rx_tend = te; rx_terr = tr;
    rx_col = col;
    if (fwd) exp_q.push_back({b, d});
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tend = 1'b0; rx_terr = 1'b0; rx_col = 1'b0;
    rx_tdatab = '0;
  endtask

  task automatic wait_rx_on(input string tag);
    int n = 0;
    while (!rx_on && n < G + 10) begin @(negedge clk); n++; end
    if (!rx_on) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    seen_rx_on = 1'b0;
    while (!frame_done && n < max_cyc) begin
      @(negedge clk); n++;
      if (rx_on) seen_rx_on = 1'b1;
    end
    if (!frame_done) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic chk_frame(input string tag, input int len, input int lb,
                           input logic col, input logic err, input logic tout);
    chk({tag, "_len"},      {29'd0, frame_len}, len);
    chk({tag, "_lastbits"}, {28'd0, frame_lastbits}, lb);
    chk({tag, "_col"},      {31'd0, frame_col}, {31'd0, col});
    chk({tag, "_err"},      {31'd0, frame_err}, {31'd0, err});
    chk({tag, "_timeout"},  {31'd0, frame_timeout}, {31'd0, tout});
    chk({tag, "_pending"},  exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rx_on", {31'd0, rx_on}, 0);
    chk("rst_state", {29'd0, dbg_state}, 0);
    chk("rst_frame_len", {29'd0, frame_len}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: normal 4-byte frame, guard length
    do_start(3'd0, 20'd1000);
    chk("t1_busy_rise", {31'd0, busy}, 1);
    n = 1;
    while (!rx_on && n < 200) begin @(negedge clk); n++; end
    chk("t1_guard_cycles", n, G + 1);
    send_beat(8'h26, 4'd8, 0, 0, 0, 1);
    send_beat(8'h04, 4'd8, 0, 0, 0, 1);
    send_beat(8'h00, 4'd8, 0, 0, 0, 1);
    send_beat(8'hAB, 4'd8, 0, 0, 0, 1);
    send_beat(8'h00, 4'd0, 1, 0, 0, 0);
    wait_done("t1_done_wait", 20);
    chk_frame("t1", 4, 8, 0, 0, 0);
    @(negedge clk);
    chk("t1_frame_done_pulse", {31'd0, frame_done}, 0);
    chk("t1_busy_fall", {31'd0, busy}, 0);
    chk("t1_len_hold", {29'd0, frame_len}, 4);

    // 2: timeout, spurious beat in DRAIN
    do_start(3'd0, 20'd100);
    wait_rx_on("t2_rx_on_wait");
    n = 0;
    while (rx_on && n < 500) begin n++; @(negedge clk); end
    chk("t2_rx_on_cycles", n, 100);
    send_beat(8'hEE, 4'd8, 1, 1, 0, 0);
    wait_done("t2_done_wait", 20);
    chk_frame("t2", 0, 0, 0, 0, 1);
    @(negedge clk);

    // 3: collision, partial byte, remainb latch
    do_start(3'd3, 20'd1000);
    chk("t3_remainb", {29'd0, remainb}, 3);
    wait_rx_on("t3_rx_on_wait");
    send_beat(8'h93, 4'd8, 0, 0, 0, 1);
    send_beat(8'h05, 4'd3, 0, 0, 1, 1);
    send_beat(8'h00, 4'd0, 1, 0, 0, 0);
    wait_done("t3_done_wait", 20);
    chk_frame("t3", 2, 3, 1, 0, 0);
    @(negedge clk);

    // 4: parity error on a single end byte
    do_start(3'd0, 20'd1000);
    wait_rx_on("t4_rx_on_wait");
    send_beat(8'h5A, 4'd8, 1, 1, 0, 1);
    chk("t4_rx_on_low", {31'd0, rx_on}, 0);
    wait_done("t4_done_wait", 20);
    chk_frame("t4", 1, 8, 0, 1, 0);
    @(negedge clk);

    // 5a: overflow at MAX_BYTES
    do_start(3'd0, 20'd1000);
    wait_rx_on("t5_rx_on_wait");
    for (int i = 0; i < 5; i++)
      send_beat(8'h10 + 8'(i), 4'd8, 0, 0, 0, (i < MAXB) ? 1'b1 : 1'b0);
    chk("t5_rx_on_low", {31'd0, rx_on}, 0);
    wait_done("t5_done_wait", 20);
    chk_frame("t5", 4, 8, 0, 1, 0);
    @(negedge clk);

    // 5b: abort during guard
    do_start(3'd0, 20'd1000);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5b_len_hold", {29'd0, frame_len}, 4);
    wait_done("t5b_done_wait", 20);
    chk("t5b_no_rx_on", {31'd0, seen_rx_on}, 0);
    chk_frame("t5b", 0, 0, 0, 1, 0);
    @(negedge clk);

    // 6: reset mid-frame, then a normal frame
    do_start(3'd0, 20'd1000);
    wait_rx_on("t6_rx_on_wait");
    send_beat(8'h11, 4'd8, 0, 0, 0, 1);
    send_beat(8'h22, 4'd8, 0, 0, 0, 1);
    n = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_rx_on", {31'd0, rx_on}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_o_valid", {31'd0, o_valid}, 0);
    chk("t6_rst_frame_done", {31'd0, frame_done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_done", done_cnt, n);
    do_start(3'd0, 20'd1000);
    wait_rx_on("t6b_rx_on_wait");
    send_beat(8'h77, 4'd8, 1, 0, 0, 1);
    wait_done("t6b_done_wait", 20);
    chk_frame("t6b", 1, 8, 0, 0, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nfca_rx_frame_ctrl.md
Name: nfca_rx_frame_ctrl

Overview:
Sequences the NFC-A RX byte assembler for one PICC response frame. Handles guard time, enabling the byte assembler, frame-wait timeout, forwarding bytes, and reporting a one-cycle frame summary. Sits in the NFC-A controller between the command sequencer, which requests a receive window, and the byte assembler, which produces rx_tvalid/rx_tdata/rx_tdatab/rx_tend/rx_terr. Runs at 81.36 MHz.

Parameters:
GUARD_CYCLES, 512, number of clk cycles between accepting start and asserting rx_on (minimum >=1).
TIMEOUT_W, 20, width of the frame-wait timeout counter.
TIMEOUT_DEFAULT, 20'd400000, timeout used when start_timeout==0.
MAX_BYTES, 64, maximum number of data bytes accepted per frame.
LEN_W, $clog2(MAX_BYTES+1), width of frame_len.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  pulse: open a receive window; ignored unless busy==0.
start_remainb  in  3  bits remaining in an incomplete first byte; latched on start.
start_timeout  in  TIMEOUT_W  frame-wait limit in clk cycles; 0 selects TIMEOUT_DEFAULT; latched on start.
abort  in  1  pulse: terminate the current window.
rx_col  in  1  pulse from the bit parser on collision end; sets a sticky collision flag.
busy  out  1  1 in every state except IDLE.
rx_on  out  1  enable to the byte assembler.
remainb  out  3  latched start_remainb, held stable while busy.
rx_tvalid, rx_tdata[8], rx_tdatab[4], rx_tend, rx_terr  in  byte beat from the byte assembler (no backpressure).
o_valid  out  1  forwarded data byte strobe.
o_data  out  8  forwarded byte.
o_bits  out  4  valid bits in o_data (1..8).
frame_done  out  1  one-cycle summary pulse.
frame_len  out  LEN_W  number of bytes forwarded in the frame.
frame_lastbits  out  4  o_bits of the last forwarded byte; 0 if none.
frame_col, frame_err, frame_timeout  out  1  summary flags, valid with frame_done.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and flags cleared. Reset mid-frame drops rx_on immediately, with no frame_done.
- All outputs are registered. o_valid and frame_done are single-cycle pulses. frame_* values hold until the next frame_done.
- States: IDLE, GUARD, LISTEN, RECV, DRAIN, DONE.
- IDLE: on start, latch remainb and timeout, clear len/col/err/lastbits, go to GUARD. busy rises the next cycle.
- GUARD: count GUARD_CYCLES cycles, then go to LISTEN with rx_on=1 on the first LISTEN cycle.
- LISTEN: timeout counter starts at the latched value and decrements each cycle.
  - rx_tvalid arrives: go to RECV and process that beat in the same cycle.
  - Counter reaches 0 with no beat: rx_on=0, frame_timeout=1, go to DRAIN.
- RECV beat processing (also applies to the first beat in LISTEN):
  - Any beat with tdatab!=0: forward it with o_valid one cycle later, o_data=rx_tdata, o_bits=rx_tdatab. Increment len and set lastbits.
  - Beat with tend=1: frame_err|=terr, rx_on=0, go to DRAIN.
  - Beat with tend=0: stay in RECV.
- Overflow: a data beat arriving when len==MAX_BYTES is not forwarded. Set frame_err=1, rx_on=0, go to DRAIN.
- rx_col arriving while in LISTEN or RECV sets col. A collision frame ends on the following tend beat with terr=0.
- abort in GUARD, LISTEN or RECV: rx_on=0, frame_err=1, go to DRAIN. abort in IDLE, DRAIN or DONE is ignored.
- DRAIN: exactly 2 cycles with rx_on=0. All rx_tvalid beats are discarded, including the assembler's rx_on-off error beat. Then go to DONE.
- DONE: frame_done=1 for one cycle with len, lastbits, col, err and timeout. Go to IDLE; busy=0 the next cycle.
- Simultaneous events within a cycle, by priority: abort, then beat processing, then timeout expiry. A beat arriving in the expiry cycle cancels the timeout.
- start while busy is ignored. start coincident with rst is lost.

Test Plan:
1. Normal 4-byte frame: start (remainb=0, timeout=1000) -> rx_on rises GUARD_CYCLES+1 cycles after start. Beats 0x26,0x04,0x00,0xAB (tdatab=8) then end beat (tend=1, terr=0, tdatab=0) -> 4 o_valid pulses; frame_done with len=4, lastbits=8, col=0, err=0, timeout=0.
2. Timeout: start with timeout=100 and no beats -> rx_on high exactly 100 cycles; frame_done with timeout=1, len=0. A spurious rx_tvalid during DRAIN is not forwarded.
3. Collision: beat 0x93 (8 bits), then rx_col with beat 0x05 (tdatab=3, tend=0), then the next-cycle end beat -> o_bits=3 on the second byte; frame_done with len=2, lastbits=3, col=1, err=0.
4. Parity error: beat 0x5A (tdatab=8, tend=1, terr=1) -> byte forwarded; frame_done with len=1, err=1; rx_on low on the next cycle.
5. Overflow/abort: with MAX_BYTES=4, send 5 data beats -> 4 forwarded; frame_done with len=4, err=1. Separately, abort during GUARD -> rx_on never rises; frame_done with err=1, len=0.
6. Reset mid-RECV: assert rst after 2 bytes -> rx_on, busy, o_valid and frame_done all 0 immediately. After release, a new start works normally.
